// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   FWD_RF/FWD_W/FWD_M : forward-select encodings (regfile, ResultW, ALUOutM)
//   state_e            : controller FSM states
//   PC_REG             : architectural PC register number (never forwarded)
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// Forward-select for one E-stage source port.
//   ra            : source register of this port
//   wa3_m, wa3_w  : destination registers in M and W
//   reg_write_m/w : destination write enables in M and W
//   sel           : FWD_M if M matches, else FWD_W if W matches, else FWD_RF
// The PC register always reads from the regfile path.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REGW = 4
) (
  input  logic [REGW-1:0] ra,
  input  logic [REGW-1:0] wa3_m,
  input  logic [REGW-1:0] wa3_w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_RF;
    if (ra != REGW'(PC_REG)) begin
      if (reg_write_m && (ra == wa3_m)) begin
        sel = FWD_M;
      end else if (reg_write_w && (ra == wa3_w)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for a 5-stage (F,D,E,M,W) ARM pipeline.
//   clk, reset          : clock (rising edge), synchronous active-low reset
//   RA_D, RA_E          : packed D/E source registers, port i at [i*REGW +: REGW]
//   WA3E/M/W, RegWrite* : destination register and write enable per stage
//   MemtoRegE           : E instruction is a load
//   PCSrcD/E/M/W        : instruction in that stage writes the PC
//   BranchTakenE        : branch resolved taken in E
//   MulStartE           : multi-cycle multiply issues from E
//   MemReqM, MemReadyM  : M-stage memory request / completion
//   ForwardE            : per-port forward select (2 bits per port)
//   Stall*/Flush*       : pipeline register hold / clear-to-bubble
//   MulBusy             : multiplier occupied
//   StallCount          : saturating count of cycles with StallF=1
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned REGW    = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNTW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC*REGW-1:0] RA_D,
  input  logic [NUM_SRC*REGW-1:0] RA_E,
  input  logic [REGW-1:0]         WA3E,
  input  logic [REGW-1:0]         WA3M,
  input  logic [REGW-1:0]         WA3W,
  input  logic                    RegWriteE,
  input  logic                    RegWriteM,
  input  logic                    RegWriteW,
  input  logic                    MemtoRegE,
  input  logic                    PCSrcD,
  input  logic                    PCSrcE,
  input  logic                    PCSrcM,
  input  logic                    PCSrcW,
  input  logic                    BranchTakenE,
  input  logic                    MulStartE,
  input  logic                    MemReqM,
  input  logic                    MemReadyM,
  output logic [NUM_SRC*2-1:0]    ForwardE,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    StallE,
  output logic                    StallM,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic                    FlushM,
  output logic                    FlushW,
  output logic                    MulBusy,
  output logic [CNTW-1:0]         StallCount
);

  // Wide enough to hold MUL_LAT-1 for any MUL_LAT >= 2.
  localparam int unsigned CW = $clog2(MUL_LAT);

  state_e              state_q, state_d;
  logic [CW-1:0]       mul_cnt_q, mul_cnt_d;
  logic [CNTW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                memwait;
  logic                ldr_stall;
  logic                pc_wr_pend;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel #(.REGW(REGW)) u_fwd_sel (
      .ra          (RA_E[g*REGW +: REGW]),
      .wa3_m       (WA3M),
      .wa3_w       (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (fwd_raw[g*2 +: 2])
    );
  end

  always_comb begin
    memwait    = MemReqM & ~MemReadyM;
    pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
    ldr_stall  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (RA_D[i*REGW +: REGW] == WA3E) begin
        ldr_stall = 1'b1;
      end
    end
    ldr_stall = ldr_stall & MemtoRegE & RegWriteE & (WA3E != REGW'(PC_REG));
  end

  // Next state: the multiply counter keeps running through a memory wait, but a
  // new multiply cannot launch while M is waiting.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (MulStartE && !memwait) begin
          mul_cnt_d = CW'(MUL_LAT - 1);
          state_d   = ST_MUL_BUSY;
        end
      end
      ST_MUL_BUSY: begin
        mul_cnt_d = mul_cnt_q - CW'(1);
        if (mul_cnt_q == CW'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output priority mux: memwait > multiplier busy > load-use > normal.
  always_comb begin
    ForwardE = '0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    MulBusy  = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardE = fwd_raw;
      MulBusy  = (state_q == ST_MUL_BUSY);
      if (memwait) begin
        // E is held, so a taken branch there stays pending; no D flush yet.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (state_q == ST_MUL_BUSY) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        FlushD = BranchTakenE;
      end else if (ldr_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        FlushD = BranchTakenE;
      end else begin
        StallF = pc_wr_pend;
        FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
        FlushE = BranchTakenE;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

  localparam int unsigned NS = 3;
  localparam int unsigned RW = 4;
  localparam int unsigned ML = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = 15;

  logic           clk;
  logic           reset;
  logic [NS*RW-1:0] RA_D, RA_E;
  logic [RW-1:0]  WA3E, WA3M, WA3W;
  logic           RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic           MulStartE, MemReqM, MemReadyM;
  logic [NS*2-1:0] ForwardE;
  logic           StallF, StallD, StallE, StallM;
  logic           FlushD, FlushE, FlushM, FlushW;
  logic           MulBusy;
  logic [CW-1:0]  StallCount;

  logic [3:0] stl;
  logic [3:0] fl;
  assign stl = {StallF, StallD, StallE, StallM};
  assign fl  = {FlushD, FlushE, FlushM, FlushW};

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  hazard_ctrl_mc #(.NUM_SRC(NS), .REGW(RW), .MUL_LAT(ML), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .RA_D(RA_D), .RA_E(RA_E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MulStartE(MulStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .MulBusy(MulBusy), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    RA_D = '0; RA_E = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
    MulStartE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt < int'(CMAX)) ? exp_cnt + 1 : int'(CMAX);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    RA_E = {4'd0, 4'd0, 4'd3}; WA3M = 4'd3; RegWriteM = 1;
    MemReqM = 1; MulStartE = 1;
    cyc(); cyc();
    n_chk++; if (ForwardE !== 6'b0) begin n_fail++; $display("FAIL reset_fwd: got %b want %b", ForwardE, 6'b0); end
    n_chk++; if (stl !== 4'b0000) begin n_fail++; $display("FAIL reset_stall: got %b want %b", stl, 4'b0000); end
    n_chk++; if (fl !== 4'b1111) begin n_fail++; $display("FAIL reset_flush: got %b want %b", fl, 4'b1111); end
    n_chk++; if (MulBusy !== 1'b0) begin n_fail++; $display("FAIL reset_mulbusy: got %b want 0", MulBusy); end
    n_chk++; if (StallCount !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", StallCount); end
    clr_inputs();
    reset = 1'b1;
    cyc();
    exp_cnt = 0;
    n_chk++; if (MulBusy !== 1'b0) begin n_fail++; $display("FAIL post_reset_mulbusy: got %b want 0", MulBusy); end
    n_chk++; if ({stl, fl} !== 8'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want %b", {stl, fl}, 8'b0); end
  endtask

  task automatic test_forward();
    // port1=3 matches both M and W: M wins
    RA_E = {4'd7, 4'd3, 4'd5}; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
    #1;
    n_chk++; if (ForwardE !== 6'b001000) begin n_fail++; $display("FAIL fwd_m_wins: got %b want %b", ForwardE, 6'b001000); end
    // port0=15 never forwarded; ports 1,2 =4 take W
    RA_E = {4'd4, 4'd4, 4'd15}; WA3M = 4'd15; RegWriteM = 1; WA3W = 4'd4; RegWriteW = 1;
    #1;
    n_chk++; if (ForwardE !== 6'b010100) begin n_fail++; $display("FAIL fwd_pc_and_w: got %b want %b", ForwardE, 6'b010100); end
    // M matches but RegWriteM=0 -> falls to W
    RA_E = {4'd9, 4'd4, 4'd4}; WA3M = 4'd4; RegWriteM = 0; WA3W = 4'd4; RegWriteW = 1;
    #1;
    n_chk++; if (ForwardE !== 6'b000101) begin n_fail++; $display("FAIL fwd_m_disabled: got %b want %b", ForwardE, 6'b000101); end
    RegWriteW = 0;
    #1;
    n_chk++; if (ForwardE !== 6'b000000) begin n_fail++; $display("FAIL fwd_none: got %b want %b", ForwardE, 6'b000000); end
    n_chk++; if ({stl, fl} !== 8'b0) begin n_fail++; $display("FAIL fwd_no_stall: got %b want %b", {stl, fl}, 8'b0); end
    clr_inputs();
    cyc();
  endtask

  task automatic test_ldr_stall();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2; RA_D = {4'd2, 4'd0, 4'd1};
    #1;
    n_chk++; if (stl !== 4'b1100) begin n_fail++; $display("FAIL ldr_stall: got %b want %b", stl, 4'b1100); end
    n_chk++; if (fl !== 4'b0100) begin n_fail++; $display("FAIL ldr_flush: got %b want %b", fl, 4'b0100); end
    cyc(); bump();
    clr_inputs();
    #1;
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL ldr_count: got %0d want %0d", StallCount, exp_cnt); end
    n_chk++; if (stl !== 4'b0000) begin n_fail++; $display("FAIL ldr_release: got %b want %b", stl, 4'b0000); end
    // load to r15 does not stall
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd15; RA_D = {4'd0, 4'd0, 4'd15};
    #1;
    n_chk++; if (stl !== 4'b0000) begin n_fail++; $display("FAIL ldr_r15: got %b want %b", stl, 4'b0000); end
    RegWriteE = 0; WA3E = 4'd2; RA_D = {4'd2, 4'd0, 4'd1};
    #1;
    n_chk++; if (stl !== 4'b0000) begin n_fail++; $display("FAIL ldr_nowrite: got %b want %b", stl, 4'b0000); end
    RegWriteE = 1; BranchTakenE = 1;
    #1;
    n_chk++; if ({stl, fl} !== 8'b1100_1100) begin n_fail++; $display("FAIL ldr_branch: got %b want %b", {stl, fl}, 8'b1100_1100); end
    cyc(); bump();
    clr_inputs();
    #1;
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL ldr_branch_count: got %0d want %0d", StallCount, exp_cnt); end
  endtask

  task automatic test_pc_branch();
    cyc();
    PCSrcW = 1;
    #1;
    n_chk++; if ({stl, fl} !== 8'b0000_1000) begin n_fail++; $display("FAIL pcsrc_w: got %b want %b", {stl, fl}, 8'b0000_1000); end
    PCSrcW = 0; BranchTakenE = 1;
    #1;
    n_chk++; if ({stl, fl} !== 8'b0000_1100) begin n_fail++; $display("FAIL branch_taken: got %b want %b", {stl, fl}, 8'b0000_1100); end
    BranchTakenE = 0; PCSrcM = 1;
    #1;
    n_chk++; if ({stl, fl} !== 8'b1000_1000) begin n_fail++; $display("FAIL pcsrc_m: got %b want %b", {stl, fl}, 8'b1000_1000); end
    cyc(); bump();
    clr_inputs();
    #1;
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL pc_count: got %0d want %0d", StallCount, exp_cnt); end
  endtask

  task automatic test_mul();
    cyc();
    MulStartE = 1;
    #1;
    n_chk++; if ({MulBusy, stl} !== 5'b0_0000) begin n_fail++; $display("FAIL mul_t0: got %b want %b", {MulBusy, stl}, 5'b0_0000); end
    cyc();
    // t1: MulStartE still high and must be ignored
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1110_0010) begin n_fail++; $display("FAIL mul_t1: got %b want %b", {MulBusy, stl, fl}, 9'b1_1110_0010); end
    BranchTakenE = 1;
    #1;
    n_chk++; if (fl !== 4'b1010) begin n_fail++; $display("FAIL mul_branch: got %b want %b", fl, 4'b1010); end
    BranchTakenE = 0;
    cyc(); bump();
    MulStartE = 0;
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1110_0010) begin n_fail++; $display("FAIL mul_t2: got %b want %b", {MulBusy, stl, fl}, 9'b1_1110_0010); end
    cyc(); bump();
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1110_0010) begin n_fail++; $display("FAIL mul_t3: got %b want %b", {MulBusy, stl, fl}, 9'b1_1110_0010); end
    cyc(); bump();
    n_chk++; if ({MulBusy, stl, fl} !== 9'b0_0000_0000) begin n_fail++; $display("FAIL mul_t4: got %b want %b", {MulBusy, stl, fl}, 9'b0_0000_0000); end
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL mul_count: got %0d want %0d", StallCount, exp_cnt); end
  endtask

  task automatic test_mul_memwait();
    cyc();
    MulStartE = 1;
    cyc();
    MulStartE = 0; MemReqM = 1; MemReadyM = 0; BranchTakenE = 1;
    #1;
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1111_0001) begin n_fail++; $display("FAIL memwait_t1: got %b want %b", {MulBusy, stl, fl}, 9'b1_1111_0001); end
    BranchTakenE = 0;
    cyc(); bump();
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1111_0001) begin n_fail++; $display("FAIL memwait_t2: got %b want %b", {MulBusy, stl, fl}, 9'b1_1111_0001); end
    cyc(); bump();
    n_chk++; if ({MulBusy, stl, fl} !== 9'b1_1111_0001) begin n_fail++; $display("FAIL memwait_t3: got %b want %b", {MulBusy, stl, fl}, 9'b1_1111_0001); end
    cyc(); bump();
    // counter expired during the wait
    n_chk++; if ({MulBusy, stl} !== 5'b0_1111) begin n_fail++; $display("FAIL memwait_expired: got %b want %b", {MulBusy, stl}, 5'b0_1111); end
    MemReadyM = 1;
    #1;
    n_chk++; if ({MulBusy, stl, fl} !== 9'b0_0000_0000) begin n_fail++; $display("FAIL memwait_ready: got %b want %b", {MulBusy, stl, fl}, 9'b0_0000_0000); end
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL memwait_count: got %0d want %0d", StallCount, exp_cnt); end
    clr_inputs();
    cyc();
    // multiply blocked by memwait in RUN
    MemReqM = 1; MulStartE = 1;
    #1;
    n_chk++; if (stl !== 4'b1111) begin n_fail++; $display("FAIL memwait_run: got %b want %b", stl, 4'b1111); end
    cyc(); bump();
    clr_inputs();
    #1;
    n_chk++; if (MulBusy !== 1'b0) begin n_fail++; $display("FAIL mul_blocked: got %b want 0", MulBusy); end
    MemReqM = 1; MemReadyM = 1;
    #1;
    n_chk++; if (stl !== 4'b0000) begin n_fail++; $display("FAIL mem_zero_wait: got %b want %b", stl, 4'b0000); end
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    cyc();
    MulStartE = 1;
    cyc();
    MulStartE = 0;
    n_chk++; if (MulBusy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b want 1", MulBusy); end
    reset = 1'b0;
    #1;
    n_chk++; if ({MulBusy, stl, fl} !== 9'b0_0000_1111) begin n_fail++; $display("FAIL rmid_comb: got %b want %b", {MulBusy, stl, fl}, 9'b0_0000_1111); end
    cyc();
    exp_cnt = 0;
    n_chk++; if (StallCount !== 4'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", StallCount); end
    n_chk++; if (fl !== 4'b1111) begin n_fail++; $display("FAIL rmid_flush: got %b want %b", fl, 4'b1111); end
    reset = 1'b1;
    #1;
    n_chk++; if ({MulBusy, stl, fl} !== 9'b0) begin n_fail++; $display("FAIL rmid_aborted: got %b want %b", {MulBusy, stl, fl}, 9'b0); end
  endtask

  task automatic test_saturation();
    cyc();
    MemReqM = 1;
    for (int i = 0; i < 15; i++) begin
      cyc(); bump();
    end
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL sat_reach: got %0d want %0d", StallCount, exp_cnt); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bump();
    end
    n_chk++; if (StallCount !== CW'(exp_cnt)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", StallCount, exp_cnt); end
    clr_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    test_reset();
    test_forward();
    test_ldr_stall();
    test_pc_branch();
    test_mul();
    test_mul_memwait();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
